// File: rtl/tag_mem_array.sv
// ============================================================================
//  Module   : tag_mem_array
//  Purpose  : 3-bank x 64-word x 16-bit precharge/arm/write/sense tag memory
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_mem_array (
   input  logic        clk,
   input  logic        reset,
   input  logic        PC_B,
   input  logic        WE,
   input  logic        SE,
   input  logic [5:0]  mem_address,
   input  logic [2:0]  mem_sel,
   input  logic [15:0] mem_data_in,
   output logic [15:0] mem_read_out,
   output logic        mem_busy,
   output logic        prot_err
);

   localparam int NUM_BANKS = 3;
   localparam int NUM_WORDS = 64;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRECHARGE = 3'd1,
      ST_ARMED     = 3'd2,
      ST_WRITE     = 3'd3,
      ST_SENSE     = 3'd4
   } state_t;

   state_t      state_q;
   logic [5:0]  addr_q;
   logic [2:0]  sel_q;
   logic [15:0] rdata_q;
   logic        prot_err_q;

   // Storage is deliberately outside the reset domain: contents are non-volatile.
   logic [15:0] mem_q [0:NUM_BANKS-1][0:NUM_WORDS-1];

   logic        w_sel_onehot;
   logic [1:0]  w_bank;
   logic        w_write;

   assign w_sel_onehot = (sel_q == 3'b001) || (sel_q == 3'b010) || (sel_q == 3'b100);
   assign w_bank       = sel_q[2] ? 2'd2 : (sel_q[1] ? 2'd1 : 2'd0);
   assign w_write      = (state_q == ST_ARMED) && WE && !SE && w_sel_onehot && !reset;

   always_ff @(posedge clk) begin
      if (w_write) begin
         mem_q[w_bank][addr_q] <= mem_data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= 6'd0;
         sel_q      <= 3'd0;
         rdata_q    <= 16'd0;
         prot_err_q <= 1'b0;
      end else begin
         prot_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (WE || SE) begin
                  prot_err_q <= 1'b1;
               end else if (!PC_B) begin
                  state_q <= ST_PRECHARGE;
                  addr_q  <= mem_address;
                  sel_q   <= mem_sel;
               end
            end
            ST_PRECHARGE: begin
               if (WE || SE) begin
                  prot_err_q <= 1'b1;
               end else if (!PC_B) begin
                  addr_q <= mem_address;
                  sel_q  <= mem_sel;
               end else begin
                  state_q <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (WE || SE) begin
                  if ((WE && SE) || !w_sel_onehot) begin
                     prot_err_q <= 1'b1;
                     state_q    <= ST_IDLE;
                  end else if (WE) begin
                     state_q <= ST_WRITE;
                  end else begin
                     rdata_q <= mem_q[w_bank][addr_q];
                     state_q <= ST_SENSE;
                  end
               end else if (!PC_B) begin
                  state_q <= ST_PRECHARGE;
                  addr_q  <= mem_address;
                  sel_q   <= mem_sel;
               end
            end
            ST_WRITE: begin
               if (!WE) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_SENSE: begin
               if (!SE) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mem_read_out = rdata_q;
   assign prot_err     = prot_err_q;
   assign mem_busy     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/tag_mem_array.md
TAG_MEM_ARRAY -- requirements
Module: tag_mem_array

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 SHALL provide ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous active-high reset.
- PC_B  input  1  precharge, active low.
- WE  input  1  write enable, active high.
- SE  input  1  sense (read) enable, active high.
- mem_address  input  6  word address, 0-63.
- mem_sel  input  3  one-hot bank select: 001 = EPC, 010 = sensor1, 100 = sensor2.
- mem_data_in  input  16  write data from the memory controller.
- mem_read_out  output  16  sensed word, returned to the controller's mem_read_in.
- mem_busy  output  1  high in every state except IDLE.
- prot_err  output  1  one-cycle pulse on any access-protocol violation.
REQ-003 SHALL hold storage as 3 banks x 64 words x 16 bits.

Function
REQ-004 SHALL implement an FSM with states IDLE, PRECHARGE, ARMED, WRITE and SENSE.
REQ-005 IDLE to PRECHARGE on PC_B=0.
- Same edge: latch mem_address into addr_q and mem_sel into sel_q.
REQ-006 PRECHARGE:
- Stay while PC_B=0, re-latching address and select every cycle.
- Go to ARMED on PC_B=1.
REQ-007 ARMED, WE=1 and SE=0:
- Write mem_data_in into bank sel_q, word addr_q, on that edge.
- Go to WRITE.
REQ-008 ARMED, SE=1 and WE=0:
- Load mem_read_out with bank sel_q, word addr_q, on that edge; valid one cycle after SE is first sampled.
- Go to SENSE.
REQ-009 ARMED, PC_B=0 (WE=0, SE=0): return to PRECHARGE and re-latch.
REQ-010 ARMED with WE=0, SE=0 and PC_B=1: hold ARMED indefinitely.
REQ-011 WRITE: stay while WE=1 with no further writes; go to IDLE when WE=0.
REQ-012 SENSE: hold mem_read_out while SE=1; go to IDLE when SE=0.
REQ-013 After SENSE, mem_read_out SHALL retain its last value until the next sense.
REQ-014 WE=1 and SE=1 sampled together in ARMED:
- Pulse prot_err.
- No write, mem_read_out unchanged.
- Go to IDLE.
REQ-015 sel_q not one-hot (000, 011, 101, 110, 111) when ARMED sees WE or SE:
- Pulse prot_err.
- No access.
- Go to IDLE.
REQ-016 WE=1 or SE=1 sampled in IDLE or PRECHARGE:
- Pulse prot_err.
- No access, state unchanged.
REQ-017 prot_err SHALL be high for exactly one cycle per violating edge.
REQ-018 Sense of a word written in a previous access SHALL return the new data, with no hazard cycles.
REQ-019 All address arithmetic SHALL be 6-bit; addresses 0 and 63 are both valid, with no wrap or offset.
REQ-020 mem_read_out SHALL be registered; no combinational path from inputs to outputs except mem_busy decode from state.

Reset
REQ-021 On reset, the FSM SHALL go to IDLE, with mem_read_out=16'd0, prot_err=0, mem_busy=0, addr_q=0 and sel_q=0.
REQ-022 Reset SHALL NOT clear array contents; they model non-volatile storage.
REQ-023 Reset asserted during WRITE or SENSE:
- Abort immediately.
- A write already committed on a prior edge persists; no partial write occurs.
REQ-024 After reset deasserts, the first access SHALL require a fresh PC_B low phase.

Verification
REQ-025 Write/read EPC:
- Stimulus: PC_B low 1 cycle with sel=001, addr=5; then WE=1 with data 16'hA5C3; then WE=0; then PC_B low, addr=5; then SE=1.
- Response: mem_read_out=16'hA5C3 one cycle after SE is sampled; prot_err stays 0.
REQ-026 Bank isolation:
- Stimulus: write 16'h1111 to sensor1 addr 0, and 16'h2222 to sensor2 addr 0; then sense each bank.
- Response: reads return 16'h1111 and 16'h2222; EPC addr 0 is unchanged.
REQ-027 Boundary:
- Stimulus: write 16'hFFFF to EPC addr 63, and 16'h0001 to EPC addr 0; then sense addr 63.
- Response: mem_read_out=16'hFFFF.
REQ-028 Protocol errors:
- WE=1 in IDLE -> prot_err pulse, array unchanged.
- WE=SE=1 in ARMED -> prot_err pulse, FSM returns to IDLE.
- sel=011 -> prot_err pulse, no write.
REQ-029 Reset persistence:
- Stimulus: write 16'hBEEF to EPC addr 10; assert reset mid-SENSE; then sense addr 10 again.
- Response: mem_read_out reads 0 during reset, then 16'hBEEF after the new sense.
REQ-030 Re-precharge: PC_B pulsed low again in ARMED with a new addr=7 -> the following sense returns word 7, not the earlier address.
